uc_ctrl: RTL

Sequencing control unit for the single-cycle, data-memory-less microcontroller datapath. It decodes the 6-bit opcode and the zero flag into the datapath selects and enables (s_inc, s_inm, we, wez, ALUOp). It also runs a run/halt/single-step state machine that freezes the PC through a new pc_en strobe, and keeps a retired-instruction counter. It sits beside the datapath in the processor top; pc_en drives the enable of the PC register.

---
 rtl/uc_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/uc_ctrl.sv
// uc_ctrl: opcode decode, run/halt/step sequencing and retired-instruction
// counter for the single-cycle microcontroller datapath.
module uc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             start_halted,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             clr_cnt,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_resume;
    logic [CNT_W-1:0] r_retired;
    logic             w_exec;
    logic             w_halt_op;
    logic             w_stop;

    assign w_exec    = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_halt_op = (Opcode == 6'b111111);
    // The first cycle after leaving HALTED steps over the HALT that stopped us
    assign w_stop    = w_halt_op && !r_resume;

    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we    = 1'b0;
        wez   = 1'b0;
        ALUOp = 3'b000;
        pc_en = 1'b0;
        if (w_exec && !w_stop) begin
            pc_en = 1'b1;
            casez (Opcode)
                6'b0?????: begin
                    we    = 1'b1;
                    wez   = 1'b1;
                    ALUOp = Opcode[4:2];
                end
                6'b1000??: begin
                    s_inm = 1'b1;
                    we    = 1'b1;
                end
                6'b110000: s_inc = 1'b0;
                6'b110001: s_inc = ~zero;
                6'b110010: s_inc = zero;
                default:   s_inc = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_BOOT:   w_next = start_halted ? ST_HALTED : ST_RUN;
            ST_RUN:    if (w_stop || halt_req) w_next = ST_HALTED;
            ST_HALTED: begin
                if (run_req)       w_next = ST_RUN;
                else if (step_req) w_next = ST_STEP;
            end
            ST_STEP:   w_next = ST_HALTED;
            default:   w_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_BOOT;
            r_resume  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state  <= w_next;
            r_resume <= (r_state == ST_HALTED) && (run_req || step_req);
            if (clr_cnt)
                r_retired <= '0;
            else if (pc_en)
                r_retired <= r_retired + CNT_ONE;
        end
    end

    assign halted  = (r_state == ST_HALTED);
    assign retired = r_retired;

endmodule
